// File: rtl/ps2_pkg.sv
// Shared constants, event layout and prefix-state encoding for the PS/2 scan-code decoder.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
    localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;
    localparam int         PS2_FRAME_LAST = 10;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    typedef enum logic [1:0] {
        PFX_IDLE = 2'd0,
        PFX_E0   = 2'd1,
        PFX_F0   = 2'd2,
        PFX_E0F0 = 2'd3
    } ps2_prefix_t;

    // True when data bits plus parity bit hold an odd number of ones.
    function automatic logic ps2_odd_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame deserialiser: synchroniser, bit counter, inter-bit watchdog and frame check.
// Parity is only enforced when PS2_PARITY_CHECK_EN is defined.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       byte_err
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

`ifdef PS2_PARITY_CHECK_EN
    localparam logic PARITY_CHECK = 1'b1;
`else
    localparam logic PARITY_CHECK = 1'b0;
`endif

    logic [2:0]      sync_q, sync_d;
    logic [3:0]      count_q, count_d;
    logic [9:0]      shift_q, shift_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            sample;
    logic            frame_ok;

    assign sample  = sync_q[2] & ~sync_q[1];
    assign rx_byte = shift_q[8:1];

    // Each stored bit only loads on the sample that matches its position.
    generate
        for (genvar gi = 0; gi < PS2_FRAME_LAST; gi++) begin : g_shift
            assign shift_d[gi] = (sample && count_q == 4'(gi)) ? ps2_data : shift_q[gi];
        end
    endgenerate

    always_comb begin
        sync_d     = {sync_q[1:0], ps2_clk};
        count_d    = count_q;
        wd_d       = wd_q;
        byte_valid = 1'b0;
        byte_err   = 1'b0;
        frame_ok   = ~shift_q[0] & ps2_data
                     & (~PARITY_CHECK | ps2_odd_parity_ok(shift_q[9:1]));
        if (sample) begin
            wd_d = '0;
            if (count_q == 4'(PS2_FRAME_LAST)) begin
                count_d    = '0;
                byte_valid = frame_ok;
                byte_err   = ~frame_ok;
            end else begin
                count_d = count_q + 4'd1;
            end
        end else if (count_q != '0) begin
            if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                count_d  = '0;
                wd_d     = '0;
                byte_err = 1'b1;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
        end
    end

    // Synchroniser resets high so an idle line cannot fake a falling edge.
    always_ff @(posedge clk) begin
        if (clr) begin
            sync_q  <= 3'b111;
            count_q <= '0;
            shift_q <= '0;
            wd_q    <= '0;
        end else begin
            sync_q  <= sync_d;
            count_q <= count_d;
            shift_q <= shift_d;
            wd_q    <= wd_d;
        end
    end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard receiver: folds E0/F0 prefixes into key events and queues them in a FIFO.
// Optional parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_scan_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_AW     = 3,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    input  logic             rdn,
    output logic [7:0]       data,
    output logic             ext,
    output logic             brk,
    output logic             ready,
    output logic             overflow,
    output logic             frame_err,
    output logic [FIFO_AW:0] level
);

    localparam int               DEPTH   = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] CNT_ONE = (FIFO_AW + 1)'(1);

    logic        byte_valid, byte_err;
    logic [7:0]  rx_byte;

    ps2_prefix_t state_q, state_d;
    ps2_event_t  push_evt, head;
    logic        push, frame_err_d, frame_err_q;

    ps2_event_t       fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [FIFO_AW:0]   cnt_q, cnt_d, level_q;
    logic               ready_q, overflow_q, overflow_d;
    logic               pop, full, wr_en;

    ps2_frame_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
        .clk        (clk),
        .clr        (clr),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .byte_err   (byte_err)
    );

    always_comb begin
        state_d       = state_q;
        push          = 1'b0;
        frame_err_d   = 1'b0;
        push_evt.code = rx_byte;
        push_evt.ext  = (state_q == PFX_E0) || (state_q == PFX_E0F0);
        push_evt.brk  = (state_q == PFX_F0) || (state_q == PFX_E0F0);
        if (byte_err) begin
            state_d     = PFX_IDLE;
            frame_err_d = 1'b1;
        end else if (byte_valid) begin
            if (rx_byte == PS2_EXT_PREFIX && (state_q == PFX_IDLE || state_q == PFX_E0)) begin
                state_d = PFX_E0;
            end else if (rx_byte == PS2_BRK_PREFIX) begin
                // A second F0 after a break prefix is an impossible sequence.
                case (state_q)
                    PFX_IDLE: state_d = PFX_F0;
                    PFX_E0:   state_d = PFX_E0F0;
                    default: begin
                        state_d     = PFX_IDLE;
                        frame_err_d = 1'b1;
                    end
                endcase
            end else begin
                push    = 1'b1;
                state_d = PFX_IDLE;
            end
        end
    end

    always_comb begin
        full       = (cnt_q == (FIFO_AW + 1)'(DEPTH));
        pop        = ~rdn & ready_q & (cnt_q != '0);
        wr_en      = push & (~full | pop);
        wptr_d     = wr_en ? wptr_q + 1'b1 : wptr_q;
        rptr_d     = pop ? rptr_q + 1'b1 : rptr_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
        if (pop) begin
            overflow_d = 1'b0;
        end else if (push && full) begin
            overflow_d = 1'b1;
        end
    end

    // ready and level are deliberately one cycle behind the occupancy counter.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= PFX_IDLE;
            frame_err_q <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            level_q     <= '0;
            ready_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_err_q <= frame_err_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
            level_q     <= cnt_q;
            ready_q     <= (cnt_q != '0);
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !clr) begin
            fifo_mem[wptr_q] <= push_evt;
        end
    end

    assign head      = fifo_mem[rptr_q];
    assign data      = head.code;
    assign ext       = head.ext;
    assign brk       = head.brk;
    assign ready     = ready_q;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;
    assign level     = level_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder: table of single frames plus hand-written multi-cycle sequences.
module tb_ps2_scan_decoder;

    localparam int FIFO_AW = 3;
    localparam int TO_CYC  = 300;
`ifdef PS2_PARITY_CHECK_EN
    localparam logic PAR_CHK = 1'b1;
`else
    localparam logic PAR_CHK = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             clr, ps2_clk, ps2_data, rdn;
    logic [7:0]       data;
    logic             ext, brk, ready, overflow, frame_err;
    logic [FIFO_AW:0] level;

    int tests = 0;
    int fails = 0;
    int err_pulses = 0;
    int err_cycles = 0;
    logic err_prev = 1'b0;

    always #5 clk = ~clk;

    ps2_scan_decoder #(.FIFO_AW(FIFO_AW), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk       (clk),
        .clr       (clr),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rdn       (rdn),
        .data      (data),
        .ext       (ext),
        .brk       (brk),
        .ready     (ready),
        .overflow  (overflow),
        .frame_err (frame_err),
        .level     (level)
    );

    always @(negedge clk) begin
        if (frame_err) err_cycles++;
        if (frame_err && !err_prev) err_pulses++;
        err_prev = frame_err;
    end

    typedef struct {
        logic [7:0] code;
        logic [2:0] fault;     // bit0 bad parity, bit1 bad start, bit2 bad stop
        logic       exp_push;
        logic [9:0] exp_evt;   // {ext, brk, code}
        logic       exp_err;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (20) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] code, input logic [2:0] fault);
        logic par;
        par = ~^code ^ fault[0];
        return {~fault[2], par, code, fault[1]};
    endfunction

    task automatic send_frame(input logic [7:0] code, input logic [2:0] fault);
        logic [10:0] bits;
        bits = frame_bits(code, fault);
        for (int i = 0; i < 11; i++) ps2_bit(bits[i]);
    endtask

    task automatic pop_one();
        rdn = 1'b0;
        @(negedge clk);
        rdn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [10:0] bits;
        int e0;

        vecs[0]  = '{8'h1C, 3'b000, 1'b1, 10'h01C, 1'b0};
        vecs[1]  = '{8'h00, 3'b000, 1'b1, 10'h000, 1'b0};
        vecs[2]  = '{8'hFF, 3'b000, 1'b1, 10'h0FF, 1'b0};
        vecs[3]  = '{8'h5A, 3'b001, ~PAR_CHK, 10'h05A, PAR_CHK};
        vecs[4]  = '{8'h1C, 3'b010, 1'b0, 10'h000, 1'b1};
        vecs[5]  = '{8'h29, 3'b100, 1'b0, 10'h000, 1'b1};
        vecs[6]  = '{8'hE0, 3'b000, 1'b0, 10'h000, 1'b0};
        vecs[7]  = '{8'hF0, 3'b000, 1'b0, 10'h000, 1'b0};
        vecs[8]  = '{8'h75, 3'b000, 1'b1, 10'h375, 1'b0};
        vecs[9]  = '{8'hE0, 3'b000, 1'b0, 10'h000, 1'b0};
        vecs[10] = '{8'hE0, 3'b000, 1'b0, 10'h000, 1'b0};
        vecs[11] = '{8'h6B, 3'b000, 1'b1, 10'h26B, 1'b0};
        vecs[12] = '{8'hF0, 3'b000, 1'b0, 10'h000, 1'b0};
        vecs[13] = '{8'h1C, 3'b000, 1'b1, 10'h11C, 1'b0};
        vecs[14] = '{8'hF0, 3'b000, 1'b0, 10'h000, 1'b0};
        vecs[15] = '{8'hF0, 3'b000, 1'b0, 10'h000, 1'b1};
        vecs[16] = '{8'h1C, 3'b000, 1'b1, 10'h01C, 1'b0};
        vecs[17] = '{8'hE0, 3'b000, 1'b0, 10'h000, 1'b0};
        vecs[18] = '{8'h74, 3'b100, 1'b0, 10'h000, 1'b1};
        vecs[19] = '{8'h74, 3'b000, 1'b1, 10'h074, 1'b0};

        clr = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rdn = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ready", 16'(ready), 16'h0);
        chk("reset_level", 16'(level), 16'h0);
        chk("reset_overflow", 16'(overflow), 16'h0);
        chk("reset_frame_err", 16'(frame_err), 16'h0);
        clr = 1'b0;
        repeat (5) @(negedge clk);

        // Exact latency from last falling ps2_clk edge to ready.
        bits = frame_bits(8'h1C, 3'b000);
        for (int i = 0; i < 10; i++) ps2_bit(bits[i]);
        ps2_data = bits[10];
        repeat (10) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        chk("lat_ready_before", 16'(ready), 16'h0);
        @(negedge clk);
        chk("lat_ready_after", 16'(ready), 16'h1);
        chk("lat_level", 16'(level), 16'h1);
        chk("lat_head", 16'({ext, brk, data}), 16'h01C);
        repeat (16) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
        pop_one();
        chk("lat_drained", 16'(level), 16'h0);

        // Table of single frames, including prefix sequences.
        for (int v = 0; v < 20; v++) begin
            e0 = err_pulses;
            send_frame(vecs[v].code, vecs[v].fault);
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_level", v), 16'(level), 16'(vecs[v].exp_push));
            chk($sformatf("v%0d_err", v), 16'(err_pulses - e0), 16'(vecs[v].exp_err));
            if (vecs[v].exp_push) begin
                chk($sformatf("v%0d_event", v), 16'({ext, brk, data}), 16'(vecs[v].exp_evt));
                pop_one();
            end
        end

        // Watchdog: partial frame then silence.
        e0 = err_pulses;
        for (int i = 0; i < 4; i++) ps2_bit(1'b0);
        repeat (TO_CYC + 20) @(negedge clk);
        chk("wd_err", 16'(err_pulses - e0), 16'h1);
        chk("wd_level", 16'(level), 16'h0);
        send_frame(8'h1C, 3'b000);
        repeat (3) @(negedge clk);
        chk("wd_after_level", 16'(level), 16'h1);
        chk("wd_after_event", 16'({ext, brk, data}), 16'h01C);
        pop_one();

        // Reset in the middle of a frame and after an E0 prefix.
        send_frame(8'hE0, 3'b000);
        for (int i = 0; i < 5; i++) ps2_bit(1'b0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        e0 = err_pulses;
        send_frame(8'h1C, 3'b000);
        repeat (3) @(negedge clk);
        chk("rst_mid_level", 16'(level), 16'h1);
        chk("rst_mid_event", 16'({ext, brk, data}), 16'h01C);
        chk("rst_mid_err", 16'(err_pulses - e0), 16'h0);
        pop_one();

        // Overflow: nine events into an eight-deep FIFO.
        for (int i = 0; i < 9; i++) send_frame(8'h10 + 8'(i), 3'b000);
        repeat (3) @(negedge clk);
        chk("ovf_level", 16'(level), 16'h8);
        chk("ovf_flag", 16'(overflow), 16'h1);
        chk("ovf_head", 16'({ext, brk, data}), 16'h010);
        pop_one();
        chk("ovf_pop_flag", 16'(overflow), 16'h0);
        chk("ovf_pop_level", 16'(level), 16'h7);
        send_frame(8'h20, 3'b000);
        repeat (3) @(negedge clk);
        chk("refill_level", 16'(level), 16'h8);

        // Push and pop on the same edge while full.
        bits = frame_bits(8'h21, 3'b000);
        for (int i = 0; i < 10; i++) ps2_bit(bits[i]);
        ps2_data = bits[10];
        repeat (10) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        rdn = 1'b0;
        @(negedge clk);
        rdn = 1'b1;
        repeat (17) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
        chk("full_pp_level", 16'(level), 16'h8);
        chk("full_pp_overflow", 16'(overflow), 16'h0);

        // Drain and check order: 12..17, 20, 21 (18 was dropped).
        for (int i = 0; i < 8; i++) begin
            logic [7:0] exp_code;
            exp_code = (i < 6) ? 8'h12 + 8'(i) : 8'h20 + 8'(i - 6);
            chk($sformatf("drain%0d", i), 16'({ext, brk, data}), 16'(exp_code));
            pop_one();
        end
        chk("drain_ready", 16'(ready), 16'h0);
        chk("drain_level", 16'(level), 16'h0);
        pop_one();
        chk("empty_pop_level", 16'(level), 16'h0);

        chk("frame_err_width", 16'(err_cycles), 16'(err_pulses));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
